park_gate_arbiter: RTL and testbench

- Controller for a single shared barrier lane of the car park, serving both the entry and exit requesters.
- Arbitrates entry requests (car at Sin) against exit requests (car at Sout, fee paid), and times the bar-open pulse.
- Tracks occupancy and refuses entry when the lot is full and exit when it is empty.
- Sits between the sensor/payment front end and the bar actuators.

---
 rtl/park_gate_if.sv | 24 ++
 rtl/park_gate_arbiter.sv | 141 ++++++++++++++
 tb/tb_park_gate_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/park_gate_if.sv
// Handshake and status bundle between the car-park front end and park_gate_arbiter.
interface park_gate_if #(parameter int CNT_W = 4);
    logic             req_in;
    logic             req_out;
    logic             ack_in;
    logic             ack_out;
    logic             bar_in;
    logic             bar_out;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] free;
    logic             full;
    logic             empty;
    logic             busy;

    modport master (
        output req_in, req_out,
        input  ack_in, ack_out, bar_in, bar_out, occupancy, free, full, empty, busy
    );

    modport slave (
        input  req_in, req_out,
        output ack_in, ack_out, bar_in, bar_out, occupancy, free, full, empty, busy
    );
endinterface

// File: rtl/park_gate_arbiter.sv
// Shared barrier-lane controller: arbitrates entry/exit, times the bar pulse, tracks occupancy.
// Define PARK_EXIT_PRIORITY_EN for fixed exit priority on ties instead of round-robin.
module park_gate_arbiter #(
    parameter int PMAX         = 5,
    parameter int CNT_W        = 4,
    parameter int BAR_CYCLES   = 5000,
    parameter int GUARD_CYCLES = 2,
    parameter int TMR_W        = 13
) (
    input logic        clk,
    input logic        rst,
    park_gate_if.slave park_io
);

    typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT, GUARD} state_e;

    localparam logic [TMR_W-1:0] TMR_BAR = TMR_W'(BAR_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_GRD = TMR_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PMAX);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] free_q;
    logic             full_q, empty_q, busy_q;
    logic             ack_in_q, ack_in_d, ack_out_q, ack_out_d;
    logic             bar_in_q, bar_out_q;
    logic             ent_ok, ext_ok, pick_in, pick_out, arb_en;

    assign ent_ok = park_io.req_in  & ~full_q;
    assign ext_ok = park_io.req_out & ~empty_q;

`ifdef PARK_EXIT_PRIORITY_EN
    assign pick_out = ext_ok;
    assign pick_in  = ent_ok & ~ext_ok;
`else
    logic ptr_q, ptr_d;  // 1: exit was the side served last

    assign pick_in  = ent_ok & (~ext_ok | ptr_q);
    assign pick_out = ext_ok & ~pick_in;

    always_comb begin
        ptr_d = ptr_q;
        if (arb_en && pick_in)       ptr_d = 1'b0;
        else if (arb_en && pick_out) ptr_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 1'b1;
        else     ptr_q <= ptr_d;
    end
`endif

    // The final guard cycle doubles as the idle decision point so grants
    // stay exactly BAR_CYCLES + GUARD_CYCLES apart under continuous load.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        occ_d     = occ_q;
        ack_in_d  = 1'b0;
        ack_out_d = 1'b0;
        arb_en    = 1'b0;

        case (state_q)
            IDLE: arb_en = 1'b1;
            OPEN_IN, OPEN_OUT: begin
                if (tmr_q == '0) begin
                    if (GUARD_CYCLES == 0) begin
                        state_d = IDLE;
                        arb_en  = 1'b1;
                    end else begin
                        state_d = GUARD;
                        tmr_d   = TMR_GRD;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            GUARD: begin
                if (tmr_q == '0) begin
                    state_d = IDLE;
                    arb_en  = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (arb_en && pick_in) begin
            state_d  = OPEN_IN;
            tmr_d    = TMR_BAR;
            occ_d    = occ_q + CNT_W'(1);
            ack_in_d = 1'b1;
        end else if (arb_en && pick_out) begin
            state_d   = OPEN_OUT;
            tmr_d     = TMR_BAR;
            occ_d     = occ_q - CNT_W'(1);
            ack_out_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            occ_q     <= '0;
            free_q    <= CNT_MAX;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            busy_q    <= 1'b0;
            ack_in_q  <= 1'b0;
            ack_out_q <= 1'b0;
            bar_in_q  <= 1'b0;
            bar_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            occ_q     <= occ_d;
            free_q    <= CNT_MAX - occ_d;
            full_q    <= (occ_d == CNT_MAX);
            empty_q   <= (occ_d == '0);
            busy_q    <= (state_d != IDLE);
            ack_in_q  <= ack_in_d;
            ack_out_q <= ack_out_d;
            bar_in_q  <= (state_d == OPEN_IN);
            bar_out_q <= (state_d == OPEN_OUT);
        end
    end

    assign park_io.ack_in    = ack_in_q;
    assign park_io.ack_out   = ack_out_q;
    assign park_io.bar_in    = bar_in_q;
    assign park_io.bar_out   = bar_out_q;
    assign park_io.occupancy = occ_q;
    assign park_io.free      = free_q;
    assign park_io.full      = full_q;
    assign park_io.empty     = empty_q;
    assign park_io.busy      = busy_q;

endmodule

// File: tb/tb_park_gate_arbiter.sv
// Bench for park_gate_arbiter: directed table, corner sequences and random traffic vs a grant-timing model.
module tb_park_gate_arbiter;
    localparam int PMAX = 2, CNT_W = 4, BAR = 4, GRD = 2, TMR_W = 13;
    localparam int PERIOD = BAR + GRD;
`ifdef PARK_EXIT_PRIORITY_EN
    localparam int TIE_FIRST = 1;
`else
    localparam int TIE_FIRST = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    park_gate_if #(.CNT_W(CNT_W)) pg ();

    park_gate_arbiter #(
        .PMAX(PMAX), .CNT_W(CNT_W), .BAR_CYCLES(BAR),
        .GUARD_CYCLES(GRD), .TMR_W(TMR_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .park_io (pg)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: grants are points in time; bar/busy follow from cycles since the last grant.
    int m_occ, m_since, m_side, m_last, m_ai, m_ao;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_occ = 0; m_since = PERIOD; m_side = 0; m_last = 1; m_ai = 0; m_ao = 0;
    endtask

    task automatic model_edge(input bit ri, input bit ro);
        bit eok, xok, gi;
        m_ai = 0; m_ao = 0;
        if (m_since < PERIOD) m_since++;
        if (m_since >= PERIOD) begin
            eok = ri && (m_occ < PMAX);
            xok = ro && (m_occ > 0);
`ifdef PARK_EXIT_PRIORITY_EN
            gi = eok && !xok;
`else
            gi = eok && (!xok || m_last == 1);
`endif
            if (eok || xok) begin
                m_since = 0;
                m_side  = gi ? 0 : 1;
                m_last  = m_side;
                if (gi) begin m_occ++; m_ai = 1; end
                else    begin m_occ--; m_ao = 1; end
            end
        end
    endtask

    task automatic compare_all();
        chk("ack_in",    int'(pg.ack_in),    m_ai);
        chk("ack_out",   int'(pg.ack_out),   m_ao);
        chk("bar_in",    int'(pg.bar_in),    int'(m_since < BAR && m_side == 0));
        chk("bar_out",   int'(pg.bar_out),   int'(m_since < BAR && m_side == 1));
        chk("occupancy", int'(pg.occupancy), m_occ);
        chk("free",      int'(pg.free),      PMAX - m_occ);
        chk("full",      int'(pg.full),      int'(m_occ == PMAX));
        chk("empty",     int'(pg.empty),     int'(m_occ == 0));
        chk("busy",      int'(pg.busy),      int'(m_since < PERIOD));
        chk("bars_excl", int'(pg.bar_in & pg.bar_out), 0);
        chk("acks_excl", int'(pg.ack_in & pg.ack_out), 0);
    endtask

    // One clock: model follows the edge, outputs checked mid-cycle, acked requesters drop.
    task automatic step();
        @(posedge clk);
        model_edge(pg.req_in, pg.req_out);
        cyc++;
        @(negedge clk);
        compare_all();
        if (pg.ack_in)  pg.req_in  = 1'b0;
        if (pg.ack_out) pg.req_out = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        compare_all();
        rst = 1'b0;
    endtask

    typedef struct {
        bit ri, ro, ai, ao, bi, bo;
        int occ;
        bit busy;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int n, first, second, last_g, gcount, side_prev;
        bit ok;

        tbl[0] = '{1, 0, 1, 0, 1, 0, 1, 1};
        tbl[1] = '{0, 0, 0, 0, 1, 0, 1, 1};
        tbl[2] = '{0, 0, 0, 0, 1, 0, 1, 1};
        tbl[3] = '{0, 0, 0, 0, 1, 0, 1, 1};
        tbl[4] = '{0, 0, 0, 0, 0, 0, 1, 1};
        tbl[5] = '{0, 0, 0, 0, 0, 0, 1, 1};
        tbl[6] = '{0, 0, 0, 0, 0, 0, 1, 0};
        tbl[7] = '{0, 1, 0, 1, 0, 1, 0, 1};
        tbl[8] = '{0, 0, 0, 0, 0, 1, 0, 1};

        rst = 1'b1;
        pg.req_in = 1'b0;
        pg.req_out = 1'b0;
        model_reset();
        do_reset();

        // Single entry then single exit, cycle by cycle.
        for (int i = 0; i < 9; i++) begin
            pg.req_in  = tbl[i].ri;
            pg.req_out = tbl[i].ro;
            step();
            chk($sformatf("tbl%0d_ack_in", i),  int'(pg.ack_in),    int'(tbl[i].ai));
            chk($sformatf("tbl%0d_ack_out", i), int'(pg.ack_out),   int'(tbl[i].ao));
            chk($sformatf("tbl%0d_bar_in", i),  int'(pg.bar_in),    int'(tbl[i].bi));
            chk($sformatf("tbl%0d_bar_out", i), int'(pg.bar_out),   int'(tbl[i].bo));
            chk($sformatf("tbl%0d_occ", i),     int'(pg.occupancy), tbl[i].occ);
            chk($sformatf("tbl%0d_busy", i),    int'(pg.busy),      int'(tbl[i].busy));
        end
        repeat (6) step();

        // Fill the lot, then a third entry must wait until an exit frees a place.
        n = 0;
        for (int k = 0; k < 40; k++) begin
            pg.req_in = 1'b1;
            step();
            if (pg.ack_in) n++;
        end
        chk("full_entries", n, 2);
        chk("full_flag", int'(pg.full), 1);
        chk("full_bar_in", int'(pg.bar_in), 0);
        pg.req_in = 1'b1;
        pg.req_out = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            step();
            if (pg.ack_out) begin
                ok = 1'b1;
                chk("exit_drops_full", int'(pg.full), 0);
            end
        end
        chk("exit_when_full", int'(ok), 1);
        ok = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            step();
            n++;
            if (pg.ack_in) ok = 1'b1;
        end
        chk("waiting_entry_served", int'(ok), 1);
        chk("waiting_entry_delay", n, PERIOD);
        chk("occ_back_to_max", int'(pg.occupancy), 2);

        // One exit leaves occupancy 1 with exit served last, then a simultaneous tie.
        pg.req_in = 1'b0;
        repeat (6) step();
        pg.req_out = 1'b1;
        for (int k = 0; k < 20 && pg.req_out; k++) step();
        repeat (8) step();
        chk("tie_start_occ", int'(pg.occupancy), 1);
        pg.req_in = 1'b1;
        pg.req_out = 1'b1;
        first = -1;
        second = -1;
        for (int k = 0; k < 30 && second < 0; k++) begin
            step();
            if (pg.ack_in || pg.ack_out) begin
                if (first < 0) first = pg.ack_out ? 1 : 0;
                else second = pg.ack_out ? 1 : 0;
            end
        end
        chk("tie_first_side", first, TIE_FIRST);
        chk("tie_second_side", second, 1 - TIE_FIRST);

        // Empty lot: a held exit request is never granted.
        pg.req_in = 1'b0;
        pg.req_out = 1'b0;
        do_reset();
        pg.req_out = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (pg.ack_out || pg.bar_out) n++;
        end
        chk("empty_no_exit", n, 0);
        chk("empty_occ", int'(pg.occupancy), 0);
        pg.req_out = 1'b0;

        // Asynchronous reset during the second open cycle.
        pg.req_in = 1'b1;
        for (int k = 0; k < 10 && pg.req_in; k++) step();
        step();
        chk("pre_reset_bar_in", int'(pg.bar_in), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_bar_in", int'(pg.bar_in), 0);
        chk("async_busy", int'(pg.busy), 0);
        chk("async_occ", int'(pg.occupancy), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        pg.req_in = 1'b1;
        n = 0;
        for (int k = 0; k < 10 && pg.req_in; k++) begin
            step();
            n++;
        end
        chk("regrant_after_reset", n, 1);
        repeat (8) step();

        // Continuous demand from both sides: alternating grants, fixed spacing.
        gcount = 0;
        last_g = -1;
        side_prev = -1;
        for (int k = 0; k < 100 && gcount < 10; k++) begin
            pg.req_in = 1'b1;
            pg.req_out = 1'b1;
            step();
            if (pg.ack_in || pg.ack_out) begin
                if (last_g >= 0) begin
                    chk("grant_spacing", cyc - last_g, PERIOD);
                    chk("grant_alternates", int'(pg.ack_out), 1 - side_prev);
                end
                last_g = cyc;
                side_prev = pg.ack_out ? 1 : 0;
                gcount++;
            end
        end
        chk("alt_grant_count", gcount, 10);

        // Random traffic against the model.
        pg.req_in = 1'b0;
        pg.req_out = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) pg.req_in  = ~pg.req_in;
            if ($urandom_range(0, 3) == 0) pg.req_out = ~pg.req_out;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
